// File: rtl/mem_stage_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_stage_pkg
//  Description : Shared types and helpers for the MEM pipeline stage.
//  Revision    : 1.0  initial release
// ============================================================================
package mem_stage_pkg;

    localparam int WORD_W = 19;
    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RMW_RD = 2'd1,
        RMW_WR = 2'd2
    } mem_state_t;

    // Replace the low byte of a word, keeping the upper bits intact.
    function automatic logic [WORD_W-1:0] merge_byte(
        input logic [WORD_W-1:0] word,
        input logic [BYTE_W-1:0] newByte
    );
        return {word[WORD_W-1:BYTE_W], newByte};
    endfunction

endpackage
`default_nettype wire

// File: rtl/data_ram.sv
`default_nettype none
// ============================================================================
//  Module      : data_ram
//  Description : Single-port data RAM, synchronous read-first, synchronous write.
//  Revision    : 1.0  initial release
// ============================================================================
module data_ram #(
    parameter int DEPTH  = 512,
    parameter int WORD_W = 19,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              writeEn,
    input  logic [ADDR_W-1:0] addr,
    input  logic [WORD_W-1:0] writeData,
    output logic [WORD_W-1:0] readData
);

    logic [WORD_W-1:0] r_mem [DEPTH];
    logic [WORD_W-1:0] r_readData;

    // The array itself is never cleared; only the output register resets.
    always_ff @(posedge clk) begin
        if (writeEn) begin
            r_mem[addr] <= writeData;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_readData <= '0;
        end else begin
            r_readData <= r_mem[addr];
        end
    end

    assign readData = r_readData;

endmodule
`default_nettype wire

// File: rtl/memory_stage.sv
`default_nettype none
// ============================================================================
//  Module      : memory_stage
//  Description : MEM stage: data RAM access, byte read-modify-write, M->W register.
//  Revision    : 1.0  initial release
// ============================================================================
module memory_stage
    import mem_stage_pkg::*;
#(
    parameter int DEPTH  = 512,
    parameter int WORD_W = 19
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              RegWriteM,
    input  logic              MemWriteM,
    input  logic              ResultSrcM,
    input  logic [4:0]        RDM,
    input  logic [WORD_W-1:0] WriteDataM,
    input  logic [WORD_W-1:0] ALUResultM,
    input  logic              Cant_ByteM,
    output logic              StallM,
    output logic              RegWriteW,
    output logic              ResultSrcW,
    output logic [4:0]        RDW,
    output logic [WORD_W-1:0] ALUResultW,
    output logic [WORD_W-1:0] ReadDataW
);

    localparam int                c_addrW      = $clog2(DEPTH);
    localparam logic [WORD_W-1:0] c_depthLimit = WORD_W'(DEPTH);

    mem_state_t         r_state;
    mem_state_t         w_phase;
    mem_state_t         w_nextState;

    logic               w_inRange;
    logic               w_byteStore;
    logic               w_bubble;
    logic               w_ramWe;
    logic [WORD_W-1:0]  w_ramWdata;
    logic [WORD_W-1:0]  w_ramRdata;
    logic [c_addrW-1:0] w_idx;

    logic               r_regWriteW;
    logic               r_resultSrcW;
    logic [4:0]         r_rdW;
    logic [WORD_W-1:0]  r_aluResultW;
    logic               r_byteW;
    logic               r_inRangeW;

    assign w_idx       = ALUResultM[c_addrW-1:0];
    assign w_inRange   = (ALUResultM < c_depthLimit);
    assign w_byteStore = MemWriteM & Cant_ByteM & w_inRange;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // RMW_RD is the byte store's first cycle; it is decoded straight from the
    // incoming instruction so the stall lands in that same cycle and the whole
    // store occupies exactly two cycles.
    always_comb begin
        w_phase     = r_state;
        w_nextState = IDLE;
        StallM      = 1'b0;
        w_bubble    = 1'b0;
        w_ramWe     = 1'b0;
        w_ramWdata  = WriteDataM;

        if (r_state == IDLE && w_byteStore) begin
            w_phase = RMW_RD;
        end

        case (w_phase)
            IDLE: begin
                w_nextState = IDLE;
                w_ramWe     = MemWriteM & ~Cant_ByteM & w_inRange;
            end
            RMW_RD: begin
                w_nextState = RMW_WR;
                StallM      = 1'b1;
                w_bubble    = 1'b1;
            end
            RMW_WR: begin
                w_nextState = IDLE;
                w_ramWe     = w_byteStore;
                w_ramWdata  = merge_byte(w_ramRdata, WriteDataM[BYTE_W-1:0]);
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase

        if (reset) begin
            StallM  = 1'b0;
            w_ramWe = 1'b0;
        end
    end

    data_ram #(
        .DEPTH  (DEPTH),
        .WORD_W (WORD_W),
        .ADDR_W (c_addrW)
    ) u_dataRam (
        .clk       (clk),
        .reset     (reset),
        .writeEn   (w_ramWe),
        .addr      (w_idx),
        .writeData (w_ramWdata),
        .readData  (w_ramRdata)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_regWriteW  <= 1'b0;
            r_resultSrcW <= 1'b0;
            r_rdW        <= '0;
            r_aluResultW <= '0;
            r_byteW      <= 1'b0;
            r_inRangeW   <= 1'b0;
        end else if (w_bubble) begin
            r_regWriteW  <= 1'b0;
            r_resultSrcW <= 1'b0;
            r_rdW        <= '0;
            r_aluResultW <= ALUResultM;
            r_byteW      <= 1'b0;
            r_inRangeW   <= 1'b0;
        end else begin
            r_regWriteW  <= RegWriteM;
            r_resultSrcW <= ResultSrcM;
            r_rdW        <= RDM;
            r_aluResultW <= ALUResultM;
            r_byteW      <= Cant_ByteM;
            r_inRangeW   <= w_inRange;
        end
    end

    // Out-of-range accesses read back as zero; the RAM index simply wraps.
    always_comb begin
        ReadDataW = '0;
        if (r_inRangeW) begin
            if (r_byteW) begin
                ReadDataW = {{(WORD_W-BYTE_W){1'b0}}, w_ramRdata[BYTE_W-1:0]};
            end else begin
                ReadDataW = w_ramRdata;
            end
        end
    end

    assign RegWriteW  = r_regWriteW;
    assign ResultSrcW = r_resultSrcW;
    assign RDW        = r_rdW;
    assign ALUResultW = r_aluResultW;

endmodule
`default_nettype wire
